// File: rtl/aes_pkg.sv
// AES shared constants, arbiter FSM encoding and the
// GF(2^8) / round helpers used by the cipher datapath.
package aes_pkg;

  localparam int NK  = 4;
  localparam int NKB = NK * 32;
  localparam int NR  = NK + 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse; 0 maps to 0
  function automatic logic [7:0] ginv(
    input logic [7:0] a
  );
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  // byte i of the block sits at [127-8i]; state[r][c] = byte r+4c
  function automatic logic [127:0] aes_round(
    input logic [127:0] s,
    input logic [127:0] rk,
    input logic         last
  );
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] t;
    for (int i = 0; i < 16; i++)
      a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = a[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c];
        x1 = b[4*c+1];
        x2 = b[4*c+2];
        x3 = b[4*c+3];
        b[4*c]   = xtime(x0) ^ xtime(x1) ^ x1 ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xtime(x1) ^ xtime(x2) ^ x2 ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xtime(x2) ^ xtime(x3) ^ x3;
        b[4*c+3] = xtime(x0) ^ x0 ^ x1 ^ x2 ^ xtime(x3);
      end
    end
    t = '0;
    for (int i = 0; i < 16; i++)
      t[127-8*i -: 8] = b[i];
    return t ^ rk;
  endfunction

endpackage

// File: rtl/cipher.sv
// AES encrypt core: one registered round per cycle.
// Ports: clk, rst_n, in/key (held stable), out (ciphertext).
module cipher
  import aes_pkg::*;
#(
  parameter int Nk = NK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Nk*32-1:0] in,
  input  logic [Nk*32-1:0] key,
  output logic [Nk*32-1:0] out
);

  localparam int Nkb = Nk * 32;
  localparam int Nr  = Nk + 6;
  localparam int NW  = 4 * (Nr + 1);

  function automatic logic [32*NW-1:0] expand(
    input logic [Nkb-1:0] k
  );
    logic [31:0]      w [NW];
    logic [31:0]      t;
    logic [7:0]       rc;
    logic [32*NW-1:0] ks;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < Nk) begin
        w[i] = k[Nkb-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t  = subword({t[23:0], t[31:24]})
             ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
      ks[32*NW-1-32*i -: 32] = w[i];
    end
    return ks;
  endfunction

  logic [32*NW-1:0] ks;
  logic [127:0]     rk [Nr+1];
  logic [127:0]     st [Nr];

  // key is static for the whole operation,
  // so the schedule can be purely combinational
  assign ks = expand(key);

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk[r] = ks[32*NW-1-128*r -: 128];
  end

  // st[r] holds the state after round r+1; out is
  // valid Nr cycles after in/key settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < Nr; r++) st[r] <= '0;
    end else begin
      st[0] <= aes_round(in[Nkb-1 -: 128] ^ rk[0],
                         rk[1], Nr == 1);
      for (int r = 1; r < Nr; r++)
        st[r] <= aes_round(st[r-1], rk[r+1],
                           r == Nr - 1);
    end
  end

  always_comb begin
    out = '0;
    out[Nkb-1 -: 128] = st[Nr-1];
  end

endmodule

// File: rtl/aes_cipher_arb.sv
// Round-robin two-port front end for the shared AES core.
// Ports: req0/req1 valid/ready/in/key, resp valid/ready/out/id, busy.
module aes_cipher_arb
  import aes_pkg::*;
#(
  parameter int Nk         = NK,
  parameter int CIPHER_LAT = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [Nk*32-1:0] req0_in,
  input  logic [Nk*32-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [Nk*32-1:0] req1_in,
  input  logic [Nk*32-1:0] req1_key,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [Nk*32-1:0] resp_out,
  output logic             resp_id,
  output logic             busy
);

  localparam int Nkb = Nk * 32;
  localparam int CW  = $clog2(CIPHER_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(CIPHER_LAT - 1);

  state_e         state;
  state_e         state_nx;
  logic           last_grant;
  logic           gnt_id;
  logic           take;
  logic           done;
  logic           id_q;
  logic [CW-1:0]  cnt;
  logic [Nkb-1:0] in_q;
  logic [Nkb-1:0] key_q;
  logic [Nkb-1:0] out_q;
  logic [Nkb-1:0] c_out;

  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid)
      gnt_id = ~last_grant;
  end

  // ready is masked while reset is held so no
  // handshake can be seen during reset
  assign take = rst_n && (state == IDLE)
              && (req0_valid || req1_valid);
  assign req0_ready = take && !gnt_id;
  assign req1_ready = take && gnt_id;
  assign done = (state == RUN) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = RUN;
      RUN:     if (done) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      cnt        <= '0;
      in_q       <= '0;
      key_q      <= '0;
      out_q      <= '0;
    end else begin
      if (take) begin
        in_q       <= gnt_id ? req1_in : req0_in;
        key_q      <= gnt_id ? req1_key : req0_key;
        id_q       <= gnt_id;
        last_grant <= gnt_id;
        cnt        <= CNT_LOAD;
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (done) out_q <= c_out;
    end
  end

  cipher #(
    .Nk (Nk)
  ) u_cipher (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_q),
    .key   (key_q),
    .out   (c_out)
  );

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_out   = out_q;
  assign resp_id    = id_q;

endmodule

// File: tb/tb_aes_cipher_arb.sv
// Bench for aes_cipher_arb: vector table, corner sequences
// and a randomized arbitration run against a queue-free model.
module tb_aes_cipher_arb;

  localparam int CL = 11;
  localparam int W  = 128;

  typedef struct {
    bit           port;
    logic [W-1:0] pt;
    logic [W-1:0] key;
    logic [W-1:0] ct;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [W-1:0] req0_in = '0;
  logic [W-1:0] req0_key = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [W-1:0] req1_in = '0;
  logic [W-1:0] req1_key = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [W-1:0] resp_out;
  logic         resp_id;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  vec_t tv [4];

  aes_cipher_arb #(
    .Nk         (4),
    .CIPHER_LAT (CL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in    (req0_in),
    .req0_key   (req0_key),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in    (req1_in),
    .req1_key   (req1_key),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n)
      chk("excl_ready", req0_ready && req1_ready, 0);

  task automatic drive(input bit port, input int vi);
    if (port) begin
      req1_valid = 1'b1;
      req1_in    = tv[vi].pt;
      req1_key   = tv[vi].key;
    end else begin
      req0_valid = 1'b1;
      req0_in    = tv[vi].pt;
      req0_key   = tv[vi].key;
    end
  endtask

  task automatic wait_acc(input bit port,
                          input string tag,
                          output int tacc);
    int n;
    bit got;
    n = 0;
    got = 0;
    tacc = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) begin
        got = 1;
        tacc = cyc;
      end
      n++;
    end
    chk({tag, "_accept"}, got, 1);
  endtask

  task automatic wait_rv(input string tag);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (resp_valid) got = 1;
      else n++;
    end
    chk({tag, "_seen"}, got, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_req(input int vi, input string tag);
    int tacc;
    @(posedge clk);
    #1 drive(tv[vi].port, vi);
    wait_acc(tv[vi].port, tag, tacc);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rv(tag);
    chk({tag, "_lat"}, cyc - tacc, CL + 1);
    chk({tag, "_out"}, resp_out, tv[vi].ct);
    chk({tag, "_id"}, resp_id, tv[vi].port);
  endtask

  initial begin
    int  tacc, k, n, i0, i1, served;
    bit  ok, outst, last, eid, hs0, hs1;
    bit  e0, e1, ev;
    logic [W-1:0] ect;

    tv[0] = '{1'b0,
      128'h00112233445566778899aabbccddeeff,
      128'h000102030405060708090a0b0c0d0e0f,
      128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tv[1] = '{1'b1, 128'h0, 128'h0,
      128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    tv[2] = '{1'b1,
      128'h3243f6a8885a308d313198a2e0370734,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h3925841d02dc09fbdc118597196a0b32};
    tv[3] = '{1'b0,
      128'h6bc1bee22e409f96e93d7e117393172a,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h3ad77bb40d7a3660a89ecaf32466ef97};

    // reset state, with both requesters pushing
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rv", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_out", resp_out, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      do_req(i, $sformatf("vec%0d", i));

    // both valid from reset: 0,1,0,1
    do_reset();
    rst_n = 1'b0;
    drive(1'b0, 0);
    drive(1'b1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    n = 0;
    while (k < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (resp_valid && resp_ready) begin
        chk($sformatf("rr_id%0d", k), resp_id, k % 2);
        chk($sformatf("rr_out%0d", k), resp_out,
            (k % 2) ? tv[1].ct : tv[0].ct);
        k++;
      end
    end
    chk("rr_count", k, 4);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // held response under back-pressure
    resp_ready = 1'b0;
    @(posedge clk);
    #1 drive(1'b0, 2);
    wait_acc(1'b0, "bp", tacc);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    drive(1'b1, 1);
    wait_rv("bp");
    ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (!(resp_valid && resp_out == tv[2].ct
            && resp_id == 1'b0 && busy
            && !req0_ready && !req1_ready))
        ok = 0;
    end
    chk("bp_hold", ok, 1);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer", resp_valid, 1);
    @(negedge clk);
    chk("bp_idle", busy, 0);
    chk("bp_next_rdy1", req1_ready, 1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    drain();

    // inputs change while the core is running
    @(posedge clk);
    #1 drive(1'b0, 0);
    wait_acc(1'b0, "mid", tacc);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 req0_in = tv[2].pt;
    req0_key = tv[3].key;
    wait_rv("mid");
    chk("mid_lat", cyc - tacc, CL + 1);
    chk("mid_out", resp_out, tv[0].ct);

    // async reset while running
    @(posedge clk);
    #1 drive(1'b0, 3);
    wait_acc(1'b0, "ar", tacc);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    drive(1'b1, 1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_rv", resp_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rdy0", req0_ready, 0);
    chk("ar_rdy1", req1_ready, 0);
    chk("ar_id", resp_id, 0);
    chk("ar_out", resp_out, 0);
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, "ar_fresh");

    // randomized run against the behavioural model
    do_reset();
    outst = 0;
    last = 1;
    eid = 0;
    hs0 = 0;
    hs1 = 0;
    i0 = 0;
    i1 = 1;
    tacc = 0;
    served = 0;
    ect = '0;
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      if (hs0 || !req0_valid) begin
        i0 = $urandom_range(0, 3);
        req0_valid = ($urandom_range(0, 2) == 0);
      end else if ($urandom_range(0, 7) == 0) begin
        req0_valid = 1'b0;
      end
      if (hs1 || !req1_valid) begin
        i1 = $urandom_range(0, 3);
        req1_valid = ($urandom_range(0, 2) == 0);
      end else if ($urandom_range(0, 7) == 0) begin
        req1_valid = 1'b0;
      end
      req0_in    = tv[i0].pt;
      req0_key   = tv[i0].key;
      req1_in    = tv[i1].pt;
      req1_key   = tv[i1].key;
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e0 = !outst && req0_valid && (!req1_valid || last);
      e1 = !outst && req1_valid && (!req0_valid || !last);
      ev = outst && (cyc - tacc >= CL + 1);
      chk("rnd_rdy0", req0_ready, e0);
      chk("rnd_rdy1", req1_ready, e1);
      chk("rnd_rv", resp_valid, ev);
      chk("rnd_busy", busy, outst);
      if (ev && resp_ready) begin
        chk("rnd_out", resp_out, ect);
        chk("rnd_id", resp_id, eid);
        outst = 0;
        served++;
      end
      hs0 = e0;
      hs1 = e1;
      if (e0 || e1) begin
        outst = 1;
        last  = e1;
        eid   = e1;
        ect   = e1 ? tv[i1].ct : tv[i0].ct;
        tacc  = cyc;
      end
    end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
